mprj_cfg_master: RTL and testbench
==================================

MPRJ_CFG_MASTER -- requirements
Module: mprj_cfg_master

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other ports are synchronous to the clock.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum number of stb-high cycles without ack before a transfer is aborted (range 1..65535).
REQ-003 wb_clk_i  in  1  clock.
REQ-004 wb_rst_i  in  1  asynchronous active-low reset.
REQ-005 cmd_valid  in  1  command present.
REQ-006 cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-007 cmd_we  in  1  1 = write, 0 = read.
REQ-008 cmd_verify  in  1  with cmd_we=1: write, then read back the same address and compare.
REQ-009 cmd_adr  in  32  target address.
REQ-010 cmd_dat  in  32  write data.
REQ-011 cmd_sel  in  4  byte enables.
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  response consumed when high together with rsp_valid.
REQ-014 rsp_dat  out  32  read data: read-back value for verify, 0 for a plain write.
REQ-015 rsp_err  out  1  timeout or verify mismatch.
REQ-016 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone classic initiator controls.
REQ-017 wb_adr_o  out  32; wb_dat_o  out  32; wb_sel_o  out  4  Wishbone address, write data and byte enables.
REQ-018 wb_ack_i  in  1; wb_dat_i  in  32  Wishbone acknowledge and read data.

Function
REQ-019 The FSM SHALL have the states IDLE, WRITE, GAP, READ and RESP.
REQ-020 cmd_ready SHALL be high only in IDLE; all cmd_* inputs are latched on the accepting clock edge.
REQ-021 After acceptance at edge T, wb_cyc_o and wb_stb_o SHALL be high from T+1 in WRITE (cmd_we=1) or READ (cmd_we=0), with adr, dat, sel and we registered and held stable for the whole transfer.
REQ-022 On the first edge at which wb_ack_i=1 while stb is high, the block SHALL drop cyc and stb after that edge; in READ it SHALL also capture wb_dat_i.
REQ-023 After a write completes: if verify=0 the next state SHALL be RESP; if verify=1 the next state SHALL be GAP, a single cycle with cyc and stb low, then READ to the same address and sel.
REQ-024 In RESP, rsp_valid SHALL be high and rsp_dat and rsp_err SHALL be stable until the edge where rsp_ready=1, after which the state SHALL return to IDLE; rsp_ready asserted outside RESP has no effect.
REQ-025 Minimum latency from acceptance to rsp_valid SHALL be 2 cycles for a single transfer with a zero-wait ack, and 4 cycles for a verify.
REQ-026 Verify mismatch SHALL be flagged when (read data XOR cmd_dat) masked by the expanded cmd_sel is nonzero; rsp_err=1 and rsp_dat holds the raw read value.
REQ-027 Between any two transfers, stb SHALL be low for at least 1 cycle, so an ack still high from the previous transfer is never sampled.
REQ-028 wb_we_o SHALL be 0 in READ; wb_dat_o SHALL be don't-care outside WRITE but held at its last value.

Reset
REQ-029 While wb_rst_i=0, all outputs SHALL be 0 immediately (asynchronously), with state IDLE and the counters cleared.
REQ-030 Reset asserted mid-transfer SHALL drop cyc and stb at once, discard the pending response, and show cmd_ready=1 on the first edge after release.

Configuration
REQ-031 With macro MPRJ_CFG_MASTER_TIMEOUT_EN defined, a 16-bit counter SHALL count cycles of stb high with no ack. On reaching TIMEOUT_CYCLES the transfer SHALL be aborted: cyc and stb dropped, RESP entered, rsp_err=1, rsp_dat=0, and a verify's read phase skipped.
REQ-032 Without the macro, no counter SHALL be present and the block SHALL wait for ack indefinitely; rsp_err then reflects only verify mismatch.

Verification
REQ-033 Write to 0x26000004, data 0x0000005A, sel 0xF, slave acks on the first stb cycle -> one cyc/stb pulse of 1 cycle with we=1; rsp_valid 2 cycles after acceptance; rsp_err=0, rsp_dat=0.
REQ-034 Read from 0x26000004, slave returns 0x0000005A after 3 wait states -> stb high for 4 cycles; rsp_dat=0x0000005A, rsp_err=0.
REQ-035 Verify write 0x00000033 with a slave that stores only bits [7:0] -> write, 1-cycle gap with stb low, read; rsp_err=0. Repeat with data 0x00000133 -> rsp_err=1, rsp_dat=0x00000033.
REQ-036 With the macro and TIMEOUT_CYCLES=8, a slave that never acks -> stb high for exactly 8 cycles, then rsp_err=1, rsp_dat=0. Without the macro -> stb stays high for 1000 cycles.
REQ-037 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_dat held and cmd_ready=0 throughout; a new cmd_valid is not accepted until 1 cycle after the handshake.
REQ-038 Assert wb_rst_i=0 in the middle of the READ phase of a verify -> cyc, stb and rsp_valid go low at once; after release, the next command completes normally with no stale response.

Source files
------------

// File: rtl/mprj_cfg_master.sv
// mprj_cfg_master: Wishbone classic configuration master with optional write-then-verify.
// Define MPRJ_CFG_MASTER_TIMEOUT_EN to abort transfers that see no ack within TIMEOUT_CYCLES.
module mprj_cfg_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic        cmd_verify,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_GAP   = 3'd2,
    ST_READ  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic        cmd_ready_r, cyc_r, stb_r, we_r, verify_r;
  logic        rsp_valid_r, rsp_err_r;
  logic [31:0] adr_r, dat_r, rsp_dat_r;
  logic [3:0]  sel_r;
  logic        accept_s, ack_s, timeout_s, mismatch_s, enter_resp_s;

  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = 32'd0;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

  assign accept_s     = cmd_valid & cmd_ready_r;
  assign ack_s        = stb_r & wb_ack_i;
  // Only bytes enabled by the original command take part in the verify compare.
  assign mismatch_s   = |((wb_dat_i ^ dat_r) & sel_mask(sel_r));
  assign enter_resp_s = (state_r != ST_RESP) && (state_s == ST_RESP);

`ifdef MPRJ_CFG_MASTER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt_r;

  assign timeout_s = stb_r & ~wb_ack_i & (to_cnt_r == TO_LAST);

  // Counts stb-high cycles without ack; cleared whenever stb drops or a transfer ends.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      to_cnt_r <= 16'd0;
    end else if (stb_r && !wb_ack_i && !timeout_s) begin
      to_cnt_r <= to_cnt_r + 16'd1;
    end else begin
      to_cnt_r <= 16'd0;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (cmd_we) state_s = ST_WRITE;
          else        state_s = ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (ack_s) begin
          if (verify_r) state_s = ST_GAP;
          else          state_s = ST_RESP;
        end else if (timeout_s) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_GAP:  state_s = ST_READ;
      ST_READ: begin
        if (ack_s || timeout_s) state_s = ST_RESP;
        else                    state_s = ST_READ;
      end
      ST_RESP: begin
        if (rsp_ready) state_s = ST_IDLE;
        else           state_s = ST_RESP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Registered bus/handshake outputs, command latch and response capture
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      cmd_ready_r <= 1'b0;
      cyc_r       <= 1'b0;
      stb_r       <= 1'b0;
      we_r        <= 1'b0;
      verify_r    <= 1'b0;
      adr_r       <= 32'd0;
      dat_r       <= 32'd0;
      sel_r       <= 4'd0;
      rsp_valid_r <= 1'b0;
      rsp_dat_r   <= 32'd0;
      rsp_err_r   <= 1'b0;
    end else begin
      cmd_ready_r <= (state_s == ST_IDLE);
      cyc_r       <= (state_s == ST_WRITE) || (state_s == ST_READ);
      stb_r       <= (state_s == ST_WRITE) || (state_s == ST_READ);
      we_r        <= (state_s == ST_WRITE);
      rsp_valid_r <= (state_s == ST_RESP);
      if (accept_s) begin
        adr_r    <= cmd_adr;
        dat_r    <= cmd_dat;
        sel_r    <= cmd_sel;
        verify_r <= cmd_verify & cmd_we;
      end
      if (enter_resp_s) begin
        if (timeout_s) begin
          rsp_dat_r <= 32'd0;
          rsp_err_r <= 1'b1;
        end else if (state_r == ST_READ) begin
          rsp_dat_r <= wb_dat_i;
          rsp_err_r <= verify_r & mismatch_s;
        end else begin
          rsp_dat_r <= 32'd0;
          rsp_err_r <= 1'b0;
        end
      end
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign wb_cyc_o  = cyc_r;
  assign wb_stb_o  = stb_r;
  assign wb_we_o   = we_r;
  assign wb_adr_o  = adr_r;
  assign wb_dat_o  = dat_r;
  assign wb_sel_o  = sel_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_dat   = rsp_dat_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_mprj_cfg_master.sv
// Self-checking bench for mprj_cfg_master: directed scenarios plus randomized commands
// against a word-array reference model; honours MPRJ_CFG_MASTER_TIMEOUT_EN.
module tb_mprj_cfg_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we, cmd_verify;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;

  int errs = 0;
  int checks = 0;

  mprj_cfg_master #(.TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_verify(cmd_verify),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  always #5 clk = ~clk;

  // ---------------- Wishbone slave: 16 words, programmable wait states ----------------
  int          slv_wait = 0;
  bit          slv_never = 1'b0;
  logic [31:0] slv_store_mask = 32'hFFFF_FFFF;
  logic [31:0] slv_mem [16];
  bit          slv_inited = 1'b0;
  int          slv_cnt;
  logic [31:0] junk_r = 32'd0;
  logic        slv_ack;

  function automatic logic [31:0] byte_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  assign slv_ack  = wb_cyc_o & wb_stb_o & ~slv_never & (slv_cnt == slv_wait);
  assign wb_ack_i = slv_ack;
  assign wb_dat_i = slv_ack ? slv_mem[wb_adr_o[5:2]] : junk_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) slv_cnt <= 0;
    else if (wb_stb_o && !slv_ack) slv_cnt <= slv_cnt + 1;
    else slv_cnt <= 0;
  end

  always @(posedge clk) begin
    junk_r <= $urandom;
    if (!slv_inited) begin
      for (int i = 0; i < 16; i++) slv_mem[i] <= 32'hC0DE_0000 + 32'(i);
      slv_inited <= 1'b1;
    end else if (slv_ack && wb_we_o) begin
      slv_mem[wb_adr_o[5:2]] <= ((slv_mem[wb_adr_o[5:2]] & ~byte_mask(wb_sel_o)) |
                                 (wb_dat_o & byte_mask(wb_sel_o))) & slv_store_mask;
    end
  end

  // ---------------- reference model and observation ----------------
  logic [31:0] mem_ref [16];

  int          ob_lat, ob_np, ob_gap, ob_bus_bad;
  int          ob_len [8];
  logic        ob_we [8];
  logic [31:0] ob_dat0, ob_rdat;
  logic        ob_rerr;
  bit          ob_done;

  task automatic issue_cmd(input logic we, input logic ver, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel, output bit ok);
    cmd_we = we; cmd_verify = ver; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    else cmd_valid = 1'b0;
  endtask

  // Called just after the accepting edge; records bus activity until rsp_valid.
  task automatic watch_rsp(input logic [31:0] eadr, input logic [3:0] esel, input int budget);
    logic prev;
    prev = 1'b0;
    ob_lat = 0; ob_np = 0; ob_gap = 0; ob_bus_bad = 0; ob_done = 1'b0;
    ob_dat0 = 32'd0; ob_rdat = 32'd0; ob_rerr = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (c == 0) begin
        cmd_valid = 1'b0; cmd_adr = $urandom; cmd_dat = $urandom;
        cmd_sel = 4'($urandom); cmd_we = 1'($urandom); cmd_verify = 1'($urandom);
      end
      ob_lat++;
      if (wb_stb_o === 1'b1) begin
        if (!prev) begin
          if (ob_np < 8) ob_np++;
          ob_we[ob_np-1] = wb_we_o; ob_len[ob_np-1] = 0;
          if (ob_np == 1) ob_dat0 = wb_dat_o;
        end
        ob_len[ob_np-1]++;
        if (wb_cyc_o !== 1'b1 || wb_adr_o !== eadr || wb_sel_o !== esel || wb_we_o !== ob_we[ob_np-1])
          ob_bus_bad++;
      end else begin
        if (wb_cyc_o !== 1'b0) ob_bus_bad++;
        if (ob_np == 1) ob_gap++;
      end
      prev = wb_stb_o;
      if (rsp_valid === 1'b1) begin
        ob_done = 1'b1; ob_rdat = rsp_dat; ob_rerr = rsp_err;
        break;
      end
    end
  endtask

  task automatic rsp_finish(input int dly);
    repeat (dly) @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, wb_cyc_o, wb_stb_o, wb_we_o} !== 6'b0 || rsp_dat !== 32'd0 ||
        wb_adr_o !== 32'd0 || wb_dat_o !== 32'd0 || wb_sel_o !== 4'd0)
      begin errs++; $display("FAIL reset_outputs: ctl=%b rsp_dat=%h adr=%h, required all zero",
        {cmd_ready, rsp_valid, rsp_err, wb_cyc_o, wb_stb_o, wb_we_o}, rsp_dat, wb_adr_o); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write;
    bit ok;
    slv_wait = 0; slv_store_mask = 32'hFFFF_FFFF;
    issue_cmd(1'b1, 1'b0, 32'h2600_0004, 32'h0000_005A, 4'hF, ok);
    watch_rsp(32'h2600_0004, 4'hF, 50);
    checks++;
    if (!ok || !ob_done || ob_np !== 1 || ob_len[0] !== 1 || ob_we[0] !== 1'b1)
      begin errs++; $display("FAIL write_pulse: ok=%0d done=%0d pulses=%0d len=%0d we=%b want 1/1/1/1/1",
        ok, ob_done, ob_np, ob_len[0], ob_we[0]); end
    checks++;
    if (ob_lat !== 2) begin errs++; $display("FAIL write_latency: got %0d want 2", ob_lat); end
    checks++;
    if (ob_rdat !== 32'd0 || ob_rerr !== 1'b0 || ob_dat0 !== 32'h5A || ob_bus_bad !== 0)
      begin errs++; $display("FAIL write_rsp: rsp_dat=%h err=%b bus_dat=%h bus_bad=%0d want 0/0/5a/0",
        ob_rdat, ob_rerr, ob_dat0, ob_bus_bad); end
    rsp_finish(0);
  endtask

  task automatic test_read;
    bit ok;
    slv_wait = 3;
    issue_cmd(1'b0, 1'b0, 32'h2600_0004, 32'h0, 4'hF, ok);
    watch_rsp(32'h2600_0004, 4'hF, 50);
    checks++;
    if (!ok || ob_np !== 1 || ob_len[0] !== 4 || ob_we[0] !== 1'b0 || ob_lat !== 5 || ob_bus_bad !== 0)
      begin errs++; $display("FAIL read_bus: ok=%0d pulses=%0d len=%0d we=%b lat=%0d bad=%0d want 1/1/4/0/5/0",
        ok, ob_np, ob_len[0], ob_we[0], ob_lat, ob_bus_bad); end
    checks++;
    if (ob_rdat !== 32'h5A || ob_rerr !== 1'b0)
      begin errs++; $display("FAIL read_rsp: dat=%h err=%b want 0000005a/0", ob_rdat, ob_rerr); end
    rsp_finish(0);
  endtask

  task automatic test_verify;
    logic [31:0] vdat [3] = '{32'h0000_0033, 32'h0000_0133, 32'h0000_01AB};
    logic [3:0]  vsel [3] = '{4'hF, 4'hF, 4'h1};
    logic        verr [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] vrd  [3] = '{32'h0000_0033, 32'h0000_0033, 32'h0000_00AB};
    bit ok;
    slv_wait = 0; slv_store_mask = 32'h0000_00FF;
    for (int k = 0; k < 3; k++) begin
      issue_cmd(1'b1, 1'b1, 32'h2600_0010, vdat[k], vsel[k], ok);
      watch_rsp(32'h2600_0010, vsel[k], 50);
      checks++;
      if (!ok || ob_np !== 2 || ob_we[0] !== 1'b1 || ob_we[1] !== 1'b0 || ob_gap !== 1 || ob_lat !== 4 || ob_bus_bad !== 0)
        begin errs++; $display("FAIL verify_seq[%0d]: ok=%0d pulses=%0d we=%b%b gap=%0d lat=%0d bad=%0d want 1/2/10/1/4/0",
          k, ok, ob_np, ob_we[0], ob_we[1], ob_gap, ob_lat, ob_bus_bad); end
      checks++;
      if (ob_rdat !== vrd[k] || ob_rerr !== verr[k])
        begin errs++; $display("FAIL verify_rsp[%0d]: dat=%h err=%b want %h/%b", k, ob_rdat, ob_rerr, vrd[k], verr[k]); end
      rsp_finish(1);
    end
    slv_store_mask = 32'hFFFF_FFFF;
  endtask

  task automatic test_backpressure;
    bit ok;
    int bad;
    slv_wait = 1;
    issue_cmd(1'b0, 1'b0, 32'h2600_0004, 32'h0, 4'hF, ok);
    watch_rsp(32'h2600_0004, 4'hF, 50);
    cmd_we = 1'b0; cmd_verify = 1'b0; cmd_adr = 32'h2600_0004; cmd_sel = 4'hF; cmd_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_dat !== 32'h5A || cmd_ready !== 1'b0 || wb_cyc_o !== 1'b0) bad++;
      if (i < 4) @(negedge clk);
    end
    checks++;
    if (!ok || bad !== 0) begin errs++; $display("FAIL hold_rsp: ok=%0d violations=%0d want 1/0", ok, bad); end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || wb_cyc_o !== 1'b0 || cmd_ready !== 1'b1)
      begin errs++; $display("FAIL post_handshake: valid=%b cyc=%b ready=%b want 0/0/1", rsp_valid, wb_cyc_o, cmd_ready); end
    @(posedge clk);
    watch_rsp(32'h2600_0004, 4'hF, 50);
    checks++;
    if (!ob_done || ob_lat !== 3 || ob_rdat !== 32'h5A || ob_rerr !== 1'b0)
      begin errs++; $display("FAIL second_cmd: done=%0d lat=%0d dat=%h err=%b want 1/3/5a/0", ob_done, ob_lat, ob_rdat, ob_rerr); end
    rsp_finish(0);
  endtask

  task automatic test_reset_mid;
    bit ok, hit;
    int np, len;
    logic prev;
    slv_wait = 4;
    issue_cmd(1'b1, 1'b1, 32'h2600_0020, 32'hDEAD_BEEF, 4'hF, ok);
    np = 0; len = 0; prev = 1'b0; hit = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) cmd_valid = 1'b0;
      if (wb_stb_o === 1'b1 && !prev) begin np++; len = 0; end
      if (wb_stb_o === 1'b1) len++;
      prev = wb_stb_o;
      if (np == 2 && len == 2) begin hit = 1'b1; break; end
    end
    checks++;
    if (!ok || !hit) begin errs++; $display("FAIL reset_mid_reach: ok=%0d in_read=%0d want 1/1", ok, hit); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready} !== 4'b0)
      begin errs++; $display("FAIL reset_mid_async: cyc/stb/valid/ready=%b want 0000", {wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
      begin errs++; $display("FAIL reset_mid_release: ready=%b valid=%b want 1/0", cmd_ready, rsp_valid); end
    slv_wait = 0;
    issue_cmd(1'b0, 1'b0, 32'h2600_0020, 32'h0, 4'hF, ok);
    watch_rsp(32'h2600_0020, 4'hF, 50);
    checks++;
    if (!ok || ob_np !== 1 || ob_lat !== 2 || ob_rdat !== 32'hDEAD_BEEF || ob_rerr !== 1'b0)
      begin errs++; $display("FAIL reset_mid_next: ok=%0d pulses=%0d lat=%0d dat=%h err=%b want 1/1/2/deadbeef/0",
        ok, ob_np, ob_lat, ob_rdat, ob_rerr); end
    rsp_finish(0);
  endtask

  task automatic test_random;
    bit ok, vfy;
    int idx, w, exp_lat, exp_np;
    logic we, ver, exp_err;
    logic [31:0] adr, dat, sm, m, oldv, newv, exp_rdat;
    logic [3:0] sel;
    for (int n = 0; n < 40; n++) begin
      idx = 12 + $urandom_range(0, 3);
      adr = 32'h2600_0000 | (32'(idx) << 2);
      sm  = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      w   = $urandom_range(0, 3);
      we  = 1'($urandom); ver = 1'($urandom); dat = $urandom; sel = 4'($urandom);
      vfy = we && ver;
      m = byte_mask(sel);
      oldv = mem_ref[idx];
      newv = ((oldv & ~m) | (dat & m)) & sm;
      if (we) mem_ref[idx] = newv;
      exp_rdat = !we ? oldv : (vfy ? newv : 32'd0);
      exp_err  = vfy && (((newv ^ dat) & m) != 32'd0);
      exp_lat  = vfy ? 2 * w + 4 : w + 2;
      exp_np   = vfy ? 2 : 1;
      slv_store_mask = sm; slv_wait = w;
      issue_cmd(we, ver, adr, dat, sel, ok);
      watch_rsp(adr, sel, 60);
      checks++;
      if (!ok || !ob_done || ob_rdat !== exp_rdat || ob_rerr !== exp_err)
        begin errs++; $display("FAIL rand_rsp[%0d]: ok=%0d done=%0d dat=%h err=%b want %h/%b (we=%b vfy=%b)",
          n, ok, ob_done, ob_rdat, ob_rerr, exp_rdat, exp_err, we, ver); end
      checks++;
      if (ob_lat !== exp_lat || ob_np !== exp_np)
        begin errs++; $display("FAIL rand_timing[%0d]: lat=%0d pulses=%0d want %0d/%0d", n, ob_lat, ob_np, exp_lat, exp_np); end
      checks++;
      if (ob_bus_bad !== 0 || ob_we[0] !== we || (we && ob_dat0 !== dat) ||
          (vfy && (ob_we[1] !== 1'b0 || ob_gap !== 1)))
        begin errs++; $display("FAIL rand_bus[%0d]: bad=%0d we=%b dat=%h gap=%0d want 0/%b/%h", n, ob_bus_bad,
          ob_we[0], ob_dat0, ob_gap, we, dat); end
      rsp_finish($urandom_range(0, 2));
    end
    slv_store_mask = 32'hFFFF_FFFF;
  endtask

  task automatic test_timeout;
    bit ok;
    int bad;
    slv_wait = 0;
`ifdef MPRJ_CFG_MASTER_TIMEOUT_EN
    bad = 0;
    slv_never = 1'b1;
    for (int k = 0; k < 2; k++) begin
      issue_cmd(k == 0, k == 0, 32'h2600_0038, 32'h1234_5678, 4'hF, ok);
      watch_rsp(32'h2600_0038, 4'hF, 60);
      checks++;
      if (!ok || ob_np !== 1 || ob_len[0] !== TO || ob_lat !== TO + 1 || ob_rdat !== 32'd0 || ob_rerr !== 1'b1)
        begin errs++; $display("FAIL timeout[%0d]: ok=%0d pulses=%0d len=%0d lat=%0d dat=%h err=%b want 1/1/%0d/%0d/0/1",
          k, ok, ob_np, ob_len[0], ob_lat, ob_rdat, ob_rerr, TO, TO + 1); end
      rsp_finish(0);
    end
    slv_never = 1'b0;
`else
    slv_never = 1'b1;
    issue_cmd(1'b0, 1'b0, 32'h2600_0038, 32'h0, 4'hF, ok);
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (c == 0) cmd_valid = 1'b0;
      if (wb_stb_o !== 1'b1 || rsp_valid !== 1'b0) bad++;
    end
    checks++;
    if (!ok || bad !== 0) begin errs++; $display("FAIL no_timeout_wait: ok=%0d violations=%0d want 1/0", ok, bad); end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    slv_never = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
`endif
    issue_cmd(1'b0, 1'b0, 32'h2600_0038, 32'h0, 4'hF, ok);
    watch_rsp(32'h2600_0038, 4'hF, 60);
    checks++;
    if (!ok || ob_rdat !== mem_ref[14] || ob_rerr !== 1'b0 || ob_lat !== 2)
      begin errs++; $display("FAIL after_stall: ok=%0d dat=%h err=%b lat=%0d want 1/%h/0/2", ok, ob_rdat, ob_rerr, ob_lat, mem_ref[14]); end
    rsp_finish(0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", errs, checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_verify = 1'b0;
    cmd_adr = 32'd0; cmd_dat = 32'd0; cmd_sel = 4'd0; rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem_ref[i] = 32'hC0DE_0000 + 32'(i);
    #1;
    test_reset;
    test_write;
    test_read;
    test_verify;
    test_backpressure;
    test_reset_mid;
    test_random;
    test_timeout;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
